alu_issue_stage: RTL

Operand-issue and writeback stage wrapped around the combinational ALU. It accepts 32-bit instruction words over a valid/ready handshake and decodes them. It reads operands from a 16×32 register file and holds them in a one-deep issue register that drives the ALU inputs. It then presents the ALU result downstream and writes it back to the register file on the result handshake, with same-cycle bypass so back-to-back dependent instructions need no stall.

---
 rtl/alu_issue_stage.sv | 133 +++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// Operand-issue and writeback stage around an external combinational ALU.
// One-deep issue register with same-edge writeback-to-decode bypass.
module alu_issue_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [3:0]  alu_opcode,
    output logic [2:0]  alu_sr_cont,
    output logic [4:0]  alu_sr_bit,
    input  logic [31:0] alu_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [3:0]  res_rd,
    output logic        res_illegal,
    output logic [31:0] retire_count
);

    logic        stage_valid_q, stage_valid_d;
    logic [3:0]  opcode_q, rd_q;
    logic [31:0] in1_q, in2_q;
    logic [2:0]  sr_cont_q;
    logic [4:0]  sr_bit_q;
    logic        illegal_q;
    logic [31:0] rf_q [16];
    logic [31:0] retire_count_q;

    logic        accept, retire, wb_en;
    logic [3:0]  dec_opcode, dec_rd, dec_rs1, dec_rs2;
    logic        dec_imm_sel;
    logic [31:0] rs1_val, rs2_val, in2_dec;
    logic [2:0]  sr_cont_dec;
    logic [4:0]  sr_bit_dec;
    logic        unused_bits;

    assign dec_opcode  = in_instr[31:28];
    assign dec_rd      = in_instr[27:24];
    assign dec_rs1     = in_instr[23:20];
    assign dec_rs2     = in_instr[19:16];
    assign dec_imm_sel = in_instr[15];
    assign unused_bits = ^in_instr[6:0];

    assign in_ready = !stage_valid_q || res_ready;
    assign accept   = in_valid && in_ready;
    assign retire   = stage_valid_q && res_ready;
    assign wb_en    = retire && !illegal_q && (rd_q != 4'd0);

    // Operand read: r0 is always zero; a same-edge writeback wins over the rf.
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (dec_rs1 != 4'd0) begin
            rs1_val = (wb_en && rd_q == dec_rs1) ? alu_out : rf_q[dec_rs1];
        end
        if (dec_rs2 != 4'd0) begin
            rs2_val = (wb_en && rd_q == dec_rs2) ? alu_out : rf_q[dec_rs2];
        end
        in2_dec     = rs2_val;
        sr_cont_dec = in_instr[14:12];
        sr_bit_dec  = in_instr[11:7];
        if (dec_imm_sel) begin
            in2_dec     = {20'd0, in_instr[11:0]};
            sr_cont_dec = '0;
            sr_bit_dec  = '0;
        end
    end

    always_comb begin
        stage_valid_d = stage_valid_q;
        if (accept) begin
            stage_valid_d = 1'b1;
        end else if (retire) begin
            stage_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid_q <= 1'b0;
            opcode_q      <= '0;
            rd_q          <= '0;
            in1_q         <= '0;
            in2_q         <= '0;
            sr_cont_q     <= '0;
            sr_bit_q      <= '0;
            illegal_q     <= 1'b0;
        end else begin
            stage_valid_q <= stage_valid_d;
            if (accept) begin
                opcode_q  <= dec_opcode;
                rd_q      <= dec_rd;
                in1_q     <= rs1_val;
                in2_q     <= in2_dec;
                sr_cont_q <= sr_cont_dec;
                sr_bit_q  <= sr_bit_dec;
                illegal_q <= (dec_opcode > 4'b0101);
            end
        end
    end

    // Entry 0 is reset and never written, so it stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= '0;
            end
            retire_count_q <= '0;
        end else begin
            if (wb_en) begin
                rf_q[rd_q] <= alu_out;
            end
            if (retire && !illegal_q) begin
                retire_count_q <= retire_count_q + 32'd1;
            end
        end
    end

    assign alu_in1      = in1_q;
    assign alu_in2      = in2_q;
    assign alu_opcode   = opcode_q;
    assign alu_sr_cont  = sr_cont_q;
    assign alu_sr_bit   = sr_bit_q;
    assign res_valid    = stage_valid_q;
    assign res_rd       = rd_q;
    assign res_illegal  = illegal_q;
    assign res_data     = illegal_q ? 32'd0 : alu_out;
    assign retire_count = retire_count_q;

endmodule
